// File: rtl/mac_gen_pkg.sv
// Shared constants, types and the byte-wise CRC-32 step for the MAC frame streamer.
package mac_gen_pkg;

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t ACTIVE = 2'd1;
  localparam state_t GAP    = 2'd2;

  typedef enum logic [1:0] {
    MODE_INC     = 2'd0,
    MODE_FIXED   = 2'd1,
    MODE_NOPAD   = 2'd2,
    MODE_BAD_FCS = 2'd3
  } mode_e;

  // Stream bytes 0..7, lowest byte first on the wire.
  localparam logic [63:0] PREAMBLE_SFD     = 64'hD555_5555_5555_5555;
  localparam int unsigned HDR_BYTES        = 22;
  localparam int unsigned MIN_PAYLOAD_SIZE = 46;
  localparam int unsigned FCS_BYTES        = 4;

  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_byte_lanes.sv
// Combinational CRC-32 update over up to BPB bytes, lowest lane first, under a byte mask.
module crc32_byte_lanes
  import mac_gen_pkg::*;
#(
  parameter int unsigned BPB = 8
) (
  input  logic [31:0]      crc_in,
  input  logic [BPB*8-1:0] data,
  input  logic [BPB-1:0]   mask,
  output logic [31:0]      crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < BPB; i++) begin
      if (mask[i]) c = crc32_byte(c, data[8*i +: 8]);
    end
    crc_out = c;
  end

endmodule

// File: rtl/mac_frame_streamer.sv
// Streaming Ethernet frame source: preamble/SFD, header, payload, pad and FCS on valid/ready.
// Define MAC_GEN_STATS_EN to enable the frame and byte counters.
module mac_frame_streamer
  import mac_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH           = 64,
  parameter int unsigned PAYLOAD_MAX_SIZE     = 1500,
  parameter logic [7:0]  PAYLOAD_CHAR_PATTERN = 8'h55,
  parameter logic [7:0]  PAD_BYTE             = 8'h00,
  parameter int unsigned IFG_CYCLES           = 12
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [47:0]             i_dest_address,
  input  logic [47:0]             i_src_address,
  input  logic [15:0]             i_eth_type,
  input  logic [15:0]             i_payload_length,
  input  logic [7:0]              i_seed,
  input  logic [1:0]              i_mode,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [DATA_WIDTH/8-1:0] o_keep,
  output logic                    o_last,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [15:0]             o_frame_bytes,
  output logic [31:0]             o_frame_count,
  output logic [31:0]             o_byte_count
);

  localparam int unsigned BPB      = DATA_WIDTH / 8;
  localparam logic [15:0] MAX_LEN  = 16'(PAYLOAD_MAX_SIZE);
  localparam logic [15:0] MIN_LEN  = 16'(MIN_PAYLOAD_SIZE);
  localparam logic [15:0] IFG_LAST = (IFG_CYCLES == 0) ? 16'd0 : 16'(IFG_CYCLES - 1);

  state_t      state_q;
  mode_e       mode_q;
  logic [15:0] pos_q, lc_q, p_q, frame_bytes_q, gap_q;
  logic [31:0] crc_q;
  logic [7:0]  seed_q;
  logic        done_q;
  logic [7:0]  fld_q [14];  // dest, src, type in wire order

  logic [15:0] lc_in, p_in;
  logic [7:0]  fld_in [14];

  assign lc_in = (i_payload_length > MAX_LEN) ? MAX_LEN : i_payload_length;
  assign p_in  = ((mode_e'(i_mode) == MODE_NOPAD) || (lc_in >= MIN_LEN)) ? lc_in : MIN_LEN;

  always_comb begin
    for (int j = 0; j < 6; j++) begin
      fld_in[j]     = i_dest_address[8*(5-j) +: 8];
      fld_in[6 + j] = i_src_address[8*(5-j) +: 8];
    end
    fld_in[12] = i_eth_type[15:8];
    fld_in[13] = i_eth_type[7:0];
  end

  // Per-lane byte decode from the absolute stream position.
  logic [15:0]           lane_b, lane_k;
  logic [DATA_WIDTH-1:0] raw_data;
  logic [BPB-1:0]        keep, crc_mask, fcs_lane;
  logic [BPB-1:0][1:0]   fcs_idx;

  always_comb begin
    lane_b   = '0;
    lane_k   = '0;
    raw_data = '0;
    keep     = '0;
    crc_mask = '0;
    fcs_lane = '0;
    fcs_idx  = '0;
    for (int i = 0; i < BPB; i++) begin
      lane_b      = pos_q + 16'(i);
      lane_k      = lane_b - 16'(HDR_BYTES);
      keep[i]     = lane_b < frame_bytes_q;
      crc_mask[i] = keep[i] && (lane_b >= 16'd8) &&
                    ((lane_b < 16'(HDR_BYTES)) || (lane_k < p_q));
      if (lane_b < 16'd8) begin
        raw_data[8*i +: 8] = PREAMBLE_SFD[8*lane_b[2:0] +: 8];
      end else if (lane_b < 16'(HDR_BYTES)) begin
        raw_data[8*i +: 8] = fld_q[4'(lane_b - 16'd8)];
      end else if (lane_k < lc_q) begin
        raw_data[8*i +: 8] = (mode_q == MODE_FIXED) ? PAYLOAD_CHAR_PATTERN : seed_q + lane_k[7:0];
      end else if (lane_k < p_q) begin
        raw_data[8*i +: 8] = PAD_BYTE;
      end else begin
        fcs_lane[i] = keep[i];
        fcs_idx[i]  = 2'(lane_k - p_q);
      end
    end
  end

  logic [31:0] crc_next;

  crc32_byte_lanes #(
    .BPB (BPB)
  ) u_crc (
    .crc_in  (crc_q),
    .data    (raw_data),
    .mask    (crc_mask),
    .crc_out (crc_next)
  );

  // FCS lanes use the CRC chained through this beat's data; a pure-FCS beat has an empty mask.
  logic [31:0]           fcs;
  logic [DATA_WIDTH-1:0] beat_data;

  always_comb begin
    fcs = ~crc_next;
    if (mode_q == MODE_BAD_FCS) fcs[0] = ~fcs[0];
    beat_data = raw_data;
    for (int i = 0; i < BPB; i++) begin
      if (fcs_lane[i]) beat_data[8*i +: 8] = fcs[8*fcs_idx[i] +: 8];
    end
  end

  logic        active, beat_last, hs;
  logic [16:0] end_pos;

  assign active    = (state_q == ACTIVE);
  assign end_pos   = {1'b0, pos_q} + 17'(BPB);
  assign beat_last = end_pos >= {1'b0, frame_bytes_q};
  assign hs        = active && i_ready;

  assign o_valid       = active;
  assign o_data        = active ? beat_data : '0;
  assign o_keep        = active ? keep : '0;
  assign o_last        = active && beat_last;
  assign o_busy        = (state_q != IDLE);
  assign o_done        = done_q;
  assign o_frame_bytes = frame_bytes_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      mode_q        <= MODE_INC;
      pos_q         <= '0;
      lc_q          <= '0;
      p_q           <= '0;
      frame_bytes_q <= '0;
      gap_q         <= '0;
      crc_q         <= CRC_INIT;
      seed_q        <= '0;
      done_q        <= 1'b0;
      for (int j = 0; j < 14; j++) fld_q[j] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q       <= ACTIVE;
            mode_q        <= mode_e'(i_mode);
            seed_q        <= i_seed;
            lc_q          <= lc_in;
            p_q           <= p_in;
            frame_bytes_q <= p_in + 16'(HDR_BYTES + FCS_BYTES);
            pos_q         <= '0;
            crc_q         <= CRC_INIT;
            for (int j = 0; j < 14; j++) fld_q[j] <= fld_in[j];
          end
        end
        ACTIVE: begin
          if (hs) begin
            pos_q <= pos_q + 16'(BPB);
            crc_q <= crc_next;
            if (beat_last) begin
              done_q  <= 1'b1;
              gap_q   <= '0;
              state_q <= (IFG_CYCLES > 0) ? GAP : IDLE;
            end
          end
        end
        GAP: begin
          gap_q <= gap_q + 16'd1;
          if (gap_q == IFG_LAST) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MAC_GEN_STATS_EN
  logic [31:0] frame_cnt_q, byte_cnt_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt_q <= '0;
      byte_cnt_q  <= '0;
    end else if (hs) begin
      byte_cnt_q <= byte_cnt_q + 32'($countones(o_keep));
      if (beat_last) frame_cnt_q <= frame_cnt_q + 32'd1;
    end
  end

  assign o_frame_count = frame_cnt_q;
  assign o_byte_count  = byte_cnt_q;
`else
  assign o_frame_count = '0;
  assign o_byte_count  = '0;
`endif

endmodule

// File: tb/tb_mac_frame_streamer.sv
// Self-checking bench for mac_frame_streamer against a byte-queue frame model.
`define CHK(tag, obs, exp) \
  begin \
    n_checks++; \
    assert ((obs) === (exp)) else begin \
      n_fail++; \
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); \
    end \
  end

module tb_mac_frame_streamer;

  localparam int unsigned DW   = 64;
  localparam int unsigned BPB  = DW / 8;
  localparam int          PMAX = 1500;

  logic          clk = 1'b0;
  logic          i_rst_n, i_start, i_ready;
  logic [47:0]   i_dest_address, i_src_address;
  logic [15:0]   i_eth_type, i_payload_length;
  logic [7:0]    i_seed;
  logic [1:0]    i_mode;
  logic          o_valid, o_last, o_busy, o_done;
  logic [DW-1:0] o_data;
  logic [BPB-1:0] o_keep;
  logic [15:0]   o_frame_bytes;
  logic [31:0]   o_frame_count, o_byte_count;

  mac_frame_streamer #(
    .DATA_WIDTH (DW),
    .IFG_CYCLES (12)
  ) dut (
    .clk              (clk),
    .i_rst_n          (i_rst_n),
    .i_start          (i_start),
    .i_dest_address   (i_dest_address),
    .i_src_address    (i_src_address),
    .i_eth_type       (i_eth_type),
    .i_payload_length (i_payload_length),
    .i_seed           (i_seed),
    .i_mode           (i_mode),
    .i_ready          (i_ready),
    .o_valid          (o_valid),
    .o_data           (o_data),
    .o_keep           (o_keep),
    .o_last           (o_last),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_frame_bytes    (o_frame_bytes),
    .o_frame_count    (o_frame_count),
    .o_byte_count     (o_byte_count)
  );

  always #5 clk = ~clk;

  int             n_checks, n_fail;
  logic [7:0]     exp_q[$], got[$], t1_q[$];
  int             beats, stall_err;
  logic [BPB-1:0] last_keep;
  logic [DW-1:0]  first_beat;

  localparam logic [47:0] T1_DST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] T1_SRC = 48'h0011_2233_4455;

  // Bit-serial reflected CRC-32.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int j = 0; j < 8; j++) begin
      fb = c[0] ^ b[j];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB8_8320;
    end
    return c;
  endfunction

  task automatic build_expected(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                                input logic [15:0] l, input logic [7:0] seed, input logic [1:0] mode);
    int          lc, p;
    logic [31:0] crc;
    exp_q.delete();
    lc = (int'(l) > PMAX) ? PMAX : int'(l);
    p  = (mode == 2'd2) ? lc : ((lc < 46) ? 46 : lc);
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) exp_q.push_back(d[8*i +: 8]);
    for (int i = 5; i >= 0; i--) exp_q.push_back(s[8*i +: 8]);
    exp_q.push_back(t[15:8]);
    exp_q.push_back(t[7:0]);
    for (int k = 0; k < p; k++) begin
      if (k >= lc)            exp_q.push_back(8'h00);
      else if (mode == 2'd1)  exp_q.push_back(8'h55);
      else                    exp_q.push_back(8'(int'(seed) + k));
    end
    crc = 32'hFFFF_FFFF;
    for (int i = 8; i < exp_q.size(); i++) crc = crc_step(crc, exp_q[i]);
    crc = ~crc;
    if (mode == 2'd3) crc[0] = ~crc[0];
    for (int i = 0; i < 4; i++) exp_q.push_back(crc[8*i +: 8]);
  endtask

  task automatic start_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                             input logic [15:0] l, input logic [7:0] seed, input logic [1:0] mode,
                             input bit hold);
    i_dest_address   = d;
    i_src_address    = s;
    i_eth_type       = t;
    i_payload_length = l;
    i_seed           = seed;
    i_mode           = mode;
    i_start          = 1'b1;
    @(negedge clk);
    if (!hold) i_start = 1'b0;
  endtask

  // Runs from a negedge until the negedge right after the last handshake.
  task automatic collect(input int pct);
    logic [DW-1:0]  pd;
    logic [BPB-1:0] pk;
    logic           pl, stalled, rdy, fin;
    int             cyc;
    got.delete();
    beats = 0; stall_err = 0; stalled = 1'b0; fin = 1'b0; cyc = 0;
    pd = '0; pk = '0; pl = 1'b0;
    while (!fin && cyc < 5000) begin
      if (stalled && (o_data !== pd || o_keep !== pk || o_last !== pl || o_valid !== 1'b1))
        stall_err++;
      if (beats > 0 && o_valid !== 1'b1) stall_err++;
      rdy = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      i_ready = rdy;
      if (o_valid && rdy) begin
        if (beats == 0) first_beat = o_data;
        for (int i = 0; i < BPB; i++) if (o_keep[i]) got.push_back(o_data[8*i +: 8]);
        beats++;
        if (o_last) begin
          last_keep = o_keep;
          fin = 1'b1;
        end
      end
      stalled = o_valid && !rdy;
      pd = o_data; pk = o_keep; pl = o_last;
      @(negedge clk);
      cyc++;
    end
    i_ready = 1'b1;
    `CHK("frame_complete", fin, 1'b1)
    `CHK("done_pulse", o_done, 1'b1)
    `CHK("valid_after_last", o_valid, 1'b0)
  endtask

  task automatic check_frame(input string tag);
    int             bad, n;
    logic [BPB-1:0] ek;
    string          s;
    n   = exp_q.size();
    bad = -1;
    for (int i = 0; i < got.size() && i < n; i++) if (bad < 0 && got[i] !== exp_q[i]) bad = i;
    ek = (n % BPB == 0) ? '1 : BPB'((1 << (n % BPB)) - 1);
    s = {tag, "_len"};         `CHK(s, got.size(), n)
    s = {tag, "_first_bad"};   `CHK(s, bad, -1)
    s = {tag, "_beats"};       `CHK(s, beats, (n + BPB - 1) / BPB)
    s = {tag, "_last_keep"};   `CHK(s, last_keep, ek)
    s = {tag, "_stall"};       `CHK(s, stall_err, 0)
    s = {tag, "_frame_bytes"}; `CHK(s, o_frame_bytes, 16'(n))
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    `CHK("back_to_idle", o_busy, 1'b0)
  endtask

  task automatic run_case(input logic [15:0] l, input logic [7:0] seed, input logic [1:0] mode,
                          input int pct, input string tag);
    build_expected(T1_DST, T1_SRC, 16'h0800, l, seed, mode);
    start_frame(T1_DST, T1_SRC, 16'h0800, l, seed, mode, 1'b0);
    collect(pct);
    check_frame(tag);
    wait_idle();
  endtask

  initial begin
    logic [31:0] crc;
    string       s9;
    int          diffs, gap;
    logic [47:0] rd, rs;
    logic [15:0] rt, rl;
    logic [7:0]  rseed;
    logic [1:0]  rmode;

    n_checks = 0; n_fail = 0;
    i_rst_n = 1'b1; i_start = 1'b0; i_ready = 1'b1;
    i_dest_address = '0; i_src_address = '0; i_eth_type = '0;
    i_payload_length = '0; i_seed = '0; i_mode = '0;

    #2 i_rst_n = 1'b0;
    #1;
    `CHK("rst_valid", o_valid, 1'b0)
    `CHK("rst_busy", o_busy, 1'b0)
    `CHK("rst_done", o_done, 1'b0)
    `CHK("rst_data", o_data, 64'd0)
    `CHK("rst_keep", o_keep, 8'd0)
    `CHK("rst_last", o_last, 1'b0)
    `CHK("rst_frame_bytes", o_frame_bytes, 16'd0)
    `CHK("rst_frame_count", o_frame_count, 32'd0)
    `CHK("rst_byte_count", o_byte_count, 32'd0)
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);

    s9  = "123456789";
    crc = 32'hFFFF_FFFF;
    for (int i = 0; i < 9; i++) crc = crc_step(crc, s9[i]);
    `CHK("crc_model", ~crc, 32'hCBF4_3926)

    // Test 1: minimum frame, always ready
    build_expected(T1_DST, T1_SRC, 16'h0800, 16'd46, 8'h00, 2'd0);
    `CHK("idle_valid", o_valid, 1'b0)
    start_frame(T1_DST, T1_SRC, 16'h0800, 16'd46, 8'h00, 2'd0, 1'b0);
    `CHK("valid_rise", o_valid, 1'b1)
    `CHK("busy_active", o_busy, 1'b1)
    collect(100);
    check_frame("t1");
    `CHK("t1_size72", got.size(), 72)
    `CHK("t1_beat0", first_beat, 64'hD555_5555_5555_5555)
    t1_q = got;
    @(negedge clk);
    `CHK("done_clears", o_done, 1'b0)
    wait_idle();

    // Test 2: padding, no-padding and fixed pattern
    run_case(16'd10, 8'h00, 2'd0, 100, "t2_pad");
    `CHK("t2_pad_size", got.size(), 72)
    run_case(16'd10, 8'h00, 2'd2, 100, "t2_nopad");
    `CHK("t2_nopad_size", got.size(), 36)
    `CHK("t2_nopad_keep", last_keep, 8'h0F)
    run_case(16'd47, 8'h00, 2'd1, 100, "t2_fixed");
    `CHK("t2_fixed_beats", beats, 10)
    `CHK("t2_fixed_keep", last_keep, 8'h01)

    // Test 3: random backpressure, same bytes as test 1
    run_case(16'd46, 8'h00, 2'd0, 50, "t3");
    diffs = (got.size() == t1_q.size()) ? 0 : 1;
    for (int i = 0; i < got.size() && i < t1_q.size(); i++) if (got[i] !== t1_q[i]) diffs++;
    `CHK("t3_vs_t1", diffs, 0)

    // Test 4: bad FCS differs from test 1 only in bit 0 of the first FCS byte
    run_case(16'd46, 8'h00, 2'd3, 100, "t4");
    diffs = (got.size() == t1_q.size()) ? 0 : 1;
    for (int i = 0; i < got.size() && i < t1_q.size(); i++)
      if (got[i] !== (t1_q[i] ^ ((i == 68) ? 8'h01 : 8'h00))) diffs++;
    `CHK("t4_vs_t1", diffs, 0)

    // Test 5: start held, inputs change mid-frame, IFG spacing
    build_expected(T1_DST, T1_SRC, 16'h0800, 16'd46, 8'h00, 2'd0);
    start_frame(T1_DST, T1_SRC, 16'h0800, 16'd46, 8'h00, 2'd0, 1'b1);
    rd = {$urandom, $urandom}; rs = {$urandom, $urandom}; rt = 16'($urandom);
    rl = 16'($urandom_range(0, 80)); rseed = 8'($urandom); rmode = 2'($urandom);
    i_dest_address = rd; i_src_address = rs; i_eth_type = rt;
    i_payload_length = rl; i_seed = rseed; i_mode = rmode;
    collect(100);
    check_frame("t5a");
    gap = 0;
    while (!o_valid && gap < 100) begin
      @(negedge clk);
      gap++;
    end
    `CHK("t5_gap", gap, 13)
    i_start = 1'b0;
    build_expected(rd, rs, rt, rl, rseed, rmode);
    collect(100);
    check_frame("t5b");
    wait_idle();

    // A few random frames under random backpressure
    for (int r = 0; r < 3; r++) begin
      run_case(16'($urandom_range(0, 120)), 8'($urandom), 2'($urandom), 70, "rand");
    end

    // Test 6: asynchronous reset mid-frame, then a clean frame
    start_frame(T1_DST, T1_SRC, 16'h0800, 16'd46, 8'h00, 2'd0, 1'b0);
    i_ready = 1'b1;
    repeat (4) @(negedge clk);
    `CHK("t6_valid_before_rst", o_valid, 1'b1)
    #2 i_rst_n = 1'b0;
    #1;
    `CHK("t6_valid_in_rst", o_valid, 1'b0)
    `CHK("t6_busy_in_rst", o_busy, 1'b0)
    @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);
    `CHK("t6_no_resume", o_valid, 1'b0)
    run_case(16'd46, 8'h00, 2'd0, 100, "t6");
`ifdef MAC_GEN_STATS_EN
    `CHK("t6_frame_count", o_frame_count, 32'd1)
    `CHK("t6_byte_count", o_byte_count, 32'd72)
`else
    `CHK("t6_frame_count_off", o_frame_count, 32'd0)
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
